// File: rtl/core_pkg.sv
// Shared core definitions: RV32 opcode constants, hazard FSM state encoding and defaults.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package core_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Hazard controller states; the encoding is visible on hazard_state_op.
    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_FLUSH    = 2'd2,
        HZ_HALT     = 2'd3
    } hazard_state_e;

    // Default number of consecutive data-memory wait cycles tolerated before halting.
    localparam int unsigned DEFAULT_MEM_TIMEOUT_CYCLES = 255;

    // True when the opcode actually reads rs1 (U-type and JAL do not).
    function automatic logic opc_reads_rs1(input logic [6:0] opc);
        logic r;
        r = 1'b0;
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: r = 1'b1;
            default:                                                      r = 1'b0;
        endcase
        return r;
    endfunction

    // True when the opcode actually reads rs2 (R-type, stores, branches).
    function automatic logic opc_reads_rs2(input logic [6:0] opc);
        logic r;
        r = 1'b0;
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones.
// Latency: count_o reflects an event one cycle after inc_i is sampled.
// Backpressure: none; an event is counted every cycle inc_i is high.
module hazard_perf_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: increment on an event unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use interlock, branch flush, data-memory wait, timeout halt.
// Latency: stall/bubble/flush outputs are combinational in the cycle the condition is present.
// Backpressure: mem wait freezes PC..EX/MEM; a wait longer than MEM_TIMEOUT_CYCLES halts until reset.
// Build option: define HAZARD_CTRL_PERF_CNT_EN to get stall/flush performance counters.
module hazard_control
    import core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT_CYCLES = DEFAULT_MEM_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  id_instr_opcode_ip,
    input  logic [4:0]  ID_rs1_ip,
    input  logic [4:0]  ID_rs2_ip,
    input  logic [4:0]  ID_EX_dest_ip,
    input  logic        ID_EX_mem_read_ip,
    input  logic        branch_taken_ip,
    input  logic        dmem_req_ip,
    input  logic        dmem_ack_ip,
    output logic        pc_stall_op,
    output logic        IF_ID_stall_op,
    output logic        ID_EX_stall_op,
    output logic        EX_MEM_stall_op,
    output logic        ID_EX_bubble_op,
    output logic        MEM_WB_bubble_op,
    output logic        IF_ID_flush_op,
    output logic        ID_EX_flush_op,
    output logic [1:0]  hazard_state_op,
    output logic        halted_op,
    output logic [31:0] stall_count_op,
    output logic [31:0] flush_count_op
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT_CYCLES);

    hazard_state_e state_q, state_d;
    logic [15:0]   wait_cnt_q, wait_cnt_d;
    logic          halted_q, halted_d;

    logic mem_wait;
    logic load_use;
    logic stall_all;
    logic mem_bubble;
    logic flush;
    logic lu_fire;

    assign mem_wait = dmem_req_ip && !dmem_ack_ip;

    // Load-use: EX holds a load to a non-zero register that the ID instruction really reads.
    always_comb begin
        load_use = 1'b0;
        if (ID_EX_mem_read_ip && (ID_EX_dest_ip != 5'd0)) begin
            load_use = (opc_reads_rs1(id_instr_opcode_ip) && (ID_rs1_ip == ID_EX_dest_ip)) ||
                       (opc_reads_rs2(id_instr_opcode_ip) && (ID_rs2_ip == ID_EX_dest_ip));
        end
    end

    // Event arbitration (halt > mem wait > flush > load-use) and next-state selection.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        halted_d   = halted_q;
        stall_all  = 1'b0;
        mem_bubble = 1'b0;
        flush      = 1'b0;
        lu_fire    = 1'b0;
        // While reset is high every control output stays low; the flops clear on the edge.
        if (!reset) begin
            unique case (state_q)
                HZ_HALT: begin
                    stall_all = 1'b1;
                end
                HZ_MEM_WAIT: begin
                    if (mem_wait) begin
                        stall_all  = 1'b1;
                        mem_bubble = 1'b1;
                        if (wait_cnt_q == TIMEOUT_LIM) begin
                            state_d  = HZ_HALT;
                            halted_d = 1'b1;
                        end else begin
                            state_d    = HZ_MEM_WAIT;
                            wait_cnt_d = wait_cnt_q + 16'd1;
                        end
                    end else if (branch_taken_ip) begin
                        flush   = 1'b1;
                        state_d = HZ_FLUSH;
                    end else begin
                        // Ack (or dropped request) releases the pipeline.
                        state_d = HZ_RUN;
                    end
                end
                HZ_FLUSH: begin
                    // Flush slot: branches and load-use are masked for this one cycle.
                    if (mem_wait) begin
                        stall_all  = 1'b1;
                        mem_bubble = 1'b1;
                        state_d    = HZ_MEM_WAIT;
                    end else begin
                        state_d = HZ_RUN;
                    end
                end
                default: begin
                    if (mem_wait) begin
                        stall_all  = 1'b1;
                        mem_bubble = 1'b1;
                        state_d    = HZ_MEM_WAIT;
                    end else if (branch_taken_ip) begin
                        flush   = 1'b1;
                        state_d = HZ_FLUSH;
                    end else begin
                        lu_fire = load_use;
                        state_d = HZ_RUN;
                    end
                end
            endcase
        end
    end

    // FSM, wait counter and sticky halt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HZ_RUN;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
        end
    end

    assign pc_stall_op      = stall_all | lu_fire;
    assign IF_ID_stall_op   = stall_all | lu_fire;
    assign ID_EX_stall_op   = stall_all;
    assign EX_MEM_stall_op  = stall_all;
    assign ID_EX_bubble_op  = lu_fire;
    assign MEM_WB_bubble_op = mem_bubble;
    assign IF_ID_flush_op   = flush;
    assign ID_EX_flush_op   = flush;
    assign hazard_state_op  = state_q;
    assign halted_op        = halted_q;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    hazard_perf_counter #(.W(32)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (pc_stall_op),
        .count_o (stall_count_op)
    );

    hazard_perf_counter #(.W(32)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (IF_ID_flush_op),
        .count_o (flush_count_op)
    );
`else
    assign stall_count_op = '0;
    assign flush_count_op = '0;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed scenarios plus randomized traffic vs. a reference model.
// Latency: model expects Mealy control outputs in the same cycle, state/counters one cycle later.
// Backpressure: timeout exercised with MEM_TIMEOUT_CYCLES=4 and an ack that never arrives.
module tb_hazard_control;

    localparam int TO = 4;

    // Opcode values written out independently of the design package.
    localparam logic [6:0] K_LUI    = 7'h37;
    localparam logic [6:0] K_AUIPC  = 7'h17;
    localparam logic [6:0] K_JAL    = 7'h6F;
    localparam logic [6:0] K_JALR   = 7'h67;
    localparam logic [6:0] K_BRANCH = 7'h63;
    localparam logic [6:0] K_LOAD   = 7'h03;
    localparam logic [6:0] K_STORE  = 7'h23;
    localparam logic [6:0] K_OPIMM  = 7'h13;
    localparam logic [6:0] K_OP     = 7'h33;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opc;
    logic [4:0]  rs1, rs2, dest;
    logic        mem_read, branch, req, ack;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        idex_bubble, memwb_bubble, ifid_flush, idex_flush;
    logic [1:0]  hstate;
    logic        halted;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, updated once per clock.
    int      m_state  = 0;
    int      m_waited = 0;
    bit      m_halted = 1'b0;
    longint  m_stalls = 0;
    longint  m_flushes = 0;

    always #5 clk = ~clk;

    hazard_control #(.MEM_TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .reset              (reset),
        .id_instr_opcode_ip (opc),
        .ID_rs1_ip          (rs1),
        .ID_rs2_ip          (rs2),
        .ID_EX_dest_ip      (dest),
        .ID_EX_mem_read_ip  (mem_read),
        .branch_taken_ip    (branch),
        .dmem_req_ip        (req),
        .dmem_ack_ip        (ack),
        .pc_stall_op        (pc_stall),
        .IF_ID_stall_op     (ifid_stall),
        .ID_EX_stall_op     (idex_stall),
        .EX_MEM_stall_op    (exmem_stall),
        .ID_EX_bubble_op    (idex_bubble),
        .MEM_WB_bubble_op   (memwb_bubble),
        .IF_ID_flush_op     (ifid_flush),
        .ID_EX_flush_op     (idex_flush),
        .hazard_state_op    (hstate),
        .halted_op          (halted),
        .stall_count_op     (stall_cnt),
        .flush_count_op     (flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rd1(input logic [6:0] o);
        return (o == K_OP) || (o == K_OPIMM) || (o == K_LOAD) || (o == K_STORE) ||
               (o == K_BRANCH) || (o == K_JALR);
    endfunction

    function automatic bit rd2(input logic [6:0] o);
        return (o == K_OP) || (o == K_STORE) || (o == K_BRANCH);
    endfunction

    // One clock: predict this cycle's outputs from the rules, compare mid-cycle, then advance the model.
    task automatic tick(input string tag);
        bit         mw, lu;
        logic [7:0] ectl;
        logic [7:0] octl;
        int         nstate, nwait;
        @(negedge clk);
        mw = req && !ack;
        lu = mem_read && (dest != 0) &&
             ((rd1(opc) && rs1 == dest) || (rd2(opc) && rs2 == dest));
        // ctl bits: {pc, IF_ID, ID_EX, EX_MEM stalls, ID_EX bubble, MEM_WB bubble, IF_ID, ID_EX flush}
        ectl   = 8'h00;
        nstate = 0;
        nwait  = 0;
        if (reset) begin
            nstate = 0;
        end else if (m_state == 3) begin
            ectl   = 8'b1111_0000;
            nstate = 3;
        end else if (mw) begin
            ectl = 8'b1111_0100;
            if (m_state == 1 && m_waited == TO) begin
                nstate = 3;
            end else begin
                nstate = 1;
                nwait  = (m_state == 1) ? m_waited + 1 : 0;
            end
        end else if (branch && m_state != 2) begin
            ectl   = 8'b0000_0011;
            nstate = 2;
        end else if (lu && m_state == 0) begin
            ectl = 8'b1100_1000;
        end
        octl = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                idex_bubble, memwb_bubble, ifid_flush, idex_flush};
        chk({tag, "_ctl"},    64'(octl),   64'(ectl));
        chk({tag, "_state"},  64'(hstate), 64'(m_state));
        chk({tag, "_halted"}, 64'(halted), 64'(m_halted));
`ifdef HAZARD_CTRL_PERF_CNT_EN
        chk({tag, "_cnts"}, {stall_cnt, flush_cnt}, {m_stalls[31:0], m_flushes[31:0]});
`else
        chk({tag, "_cnts"}, {stall_cnt, flush_cnt}, 64'd0);
`endif
        @(posedge clk);
        if (reset) begin
            m_stalls  = 0;
            m_flushes = 0;
            m_halted  = 1'b0;
        end else begin
            if (ectl[7] && m_stalls  < 64'hFFFF_FFFF) m_stalls++;
            if (ectl[1] && m_flushes < 64'hFFFF_FFFF) m_flushes++;
            m_halted = (nstate == 3);
        end
        m_state  = nstate;
        m_waited = nwait;
        #1;
    endtask

    task automatic idle();
        reset = 0; opc = K_OPIMM; rs1 = 0; rs2 = 0; dest = 0;
        mem_read = 0; branch = 0; req = 0; ack = 0;
    endtask

    initial begin : main
        int n;
        logic [6:0] ops [10];
        ops = '{K_LUI, K_AUIPC, K_JAL, K_JALR, K_BRANCH, K_LOAD, K_STORE, K_OPIMM, K_OP, 7'h7F};

        // Reset state
        idle();
        reset = 1;
        tick("rst0");
        tick("rst1");
        reset = 0;
        chk("rst_state", 64'(hstate), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        tick("idle");

        // Load-use: load to x5, OP reading x5 through rs2
        mem_read = 1; dest = 5; opc = K_OP; rs1 = 3; rs2 = 5;
        #1;
        chk("lu_pc_ifid_bubble", 64'({pc_stall, ifid_stall, idex_bubble, idex_stall}), 64'b1110);
        tick("lu");
        idle();
        chk("lu_after_state", 64'(hstate), 64'd0);
        tick("lu_post");

        // LUI/AUIPC/JAL never interlock, even with register-field matches
        mem_read = 1; dest = 7; rs1 = 7; rs2 = 7;
        opc = K_LUI;   tick("lui");
        opc = K_AUIPC; tick("auipc");
        opc = K_JAL;   tick("jal");
        opc = K_STORE; tick("store_lu");
        opc = K_OPIMM; rs1 = 1; tick("opimm_rs2_only");

        // x0 destination never interlocks
        idle();
        mem_read = 1; dest = 0; rs1 = 0; opc = K_LOAD;
        #1;
        chk("x0_no_stall", 64'(pc_stall), 64'd0);
        tick("x0");

        // Memory stall: three wait cycles then the ack cycle releases
        idle();
        req = 1; ack = 0;
        tick("mw1");
        chk("mw_state_in", 64'(hstate), 64'd1);
        tick("mw2");
        tick("mw3");
        ack = 1;
        #1;
        chk("mw_ack_release", 64'(pc_stall), 64'd0);
        tick("mw_ack");
        idle();
        chk("mw_after_state", 64'(hstate), 64'd0);
        tick("mw_post");

        // Branch and load-use together: flush wins, no bubble; FLUSH lasts one cycle
        branch = 1; mem_read = 1; dest = 5; opc = K_OP; rs1 = 5;
        #1;
        chk("simul_flush_only", 64'({ifid_flush, idex_flush, idex_bubble, pc_stall}), 64'b1100);
        tick("simul");
        chk("simul_state_flush", 64'(hstate), 64'd2);
        tick("flush_slot_masked");
        idle();
        chk("flush_done", 64'(hstate), 64'd0);
        tick("flush_post");

        // Timeout: ack never comes. One entry cycle in RUN, four counted waits, then the
        // cycle that sees the count at the limit moves to HALT.
        req = 1; ack = 0;
        n = 0;
        while (hstate != 2'd3 && n < 20) begin
            tick("to");
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'd6);
        chk("timeout_halted", 64'(halted), 64'd1);
        req = 0; branch = 1; mem_read = 1; dest = 5; opc = K_OP; rs1 = 5;
        tick("halt_ignores1");
        idle();
        tick("halt_ignores2");
        reset = 1;
        tick("halt_reset");
        reset = 0;
        chk("halt_reset_state", 64'(hstate), 64'd0);
        chk("halt_reset_halted", 64'(halted), 64'd0);
        tick("after_halt");

        // Reset arriving mid-wait
        req = 1;
        tick("mrw1");
        tick("mrw2");
        reset = 1;
        tick("mrw_reset");
        idle();
        tick("mrw_post");

        // Counters: ten stall cycles after a fresh reset
        reset = 1;
        tick("cnt_rst");
        reset = 0;
        mem_read = 1; dest = 9; opc = K_LOAD; rs1 = 9;
        for (int i = 0; i < 10; i++) tick("cnt_lu");
        idle();
`ifdef HAZARD_CTRL_PERF_CNT_EN
        chk("stall_count_10", 64'(stall_cnt), 64'd10);
`else
        chk("stall_count_tied", 64'(stall_cnt), 64'd0);
`endif
        tick("cnt_post");

        // Randomized traffic; periodic no-ack windows force timeouts, random resets recover
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            opc      = ops[$urandom_range(0, 9)];
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            dest     = 5'($urandom_range(0, 3));
            mem_read = 1'($urandom_range(0, 1));
            branch   = ($urandom_range(0, 5) == 0);
            if ((i % 100) < 15) begin
                req = 1; ack = 0;
            end else begin
                req = 1'($urandom_range(0, 1));
                ack = 1'($urandom_range(0, 1));
            end
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT_CYCLES, default 255, giving the maximum consecutive cycles of data-memory wait before halt (range 1..65535).
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: id_instr_opcode_ip  in  7  opcode in the ID stage; ID_rs1_ip / ID_rs2_ip  in  5 each  ID source registers.
REQ-005 SHALL have ports: ID_EX_dest_ip  in  5  EX destination register; ID_EX_mem_read_ip  in  1  the EX instruction is a load.
REQ-006 SHALL have ports: branch_taken_ip  in  1  branch or jump resolved taken in EX; dmem_req_ip / dmem_ack_ip  in  1 each  MEM-stage request and completion.
REQ-007 SHALL have ports: pc_stall_op, IF_ID_stall_op, ID_EX_stall_op, EX_MEM_stall_op  out  1 each  hold the register.
REQ-008 SHALL have ports: ID_EX_bubble_op, MEM_WB_bubble_op, IF_ID_flush_op, ID_EX_flush_op  out  1 each  load a NOP.
REQ-009 SHALL have ports: hazard_state_op  out  2  current state; halted_op  out  1  sticky timeout flag; stall_count_op, flush_count_op  out  32 each  performance counters.

Function
REQ-010 States SHALL be RUN=0, MEM_WAIT=1, FLUSH=2, HALT=3; control outputs SHALL be combinational (Mealy) in the cycle the condition is present.
REQ-011 mem_wait SHALL be dmem_req_ip && !dmem_ack_ip.
REQ-012 While mem_wait holds in RUN, FLUSH or MEM_WAIT: assert pc, IF_ID, ID_EX and EX_MEM stalls plus MEM_WB_bubble; next state MEM_WAIT.
REQ-013 In MEM_WAIT a 16-bit wait counter SHALL increment each mem_wait cycle.
REQ-014 When the wait counter equals MEM_TIMEOUT_CYCLES with mem_wait still high, next state SHALL be HALT.
REQ-015 In MEM_WAIT, the cycle with dmem_ack_ip=1 SHALL deassert all stalls, clear the wait counter, and go to RUN.
REQ-016 Flush SHALL occur when branch_taken_ip && !mem_wait in RUN or MEM_WAIT: IF_ID_flush_op=ID_EX_flush_op=1 that cycle; next state FLUSH.
REQ-017 FLUSH SHALL last one cycle, ignore branch_taken_ip and load-use, and then go to RUN, or to MEM_WAIT if mem_wait holds.
REQ-018 Load-use SHALL be ID_EX_mem_read_ip && ID_EX_dest_ip!=0 && (rs1 match for OP, OPIMM, LOAD, STORE, BRANCH, JALR, or rs2 match for OP, STORE, BRANCH).
REQ-019 Load-use SHALL assert pc_stall_op, IF_ID_stall_op and ID_EX_bubble_op for exactly that cycle; the state stays RUN.
REQ-020 Priority SHALL be HALT > mem_wait > flush > load-use; a lower event SHALL produce no outputs in a cycle where a higher one fires.
REQ-021 HALT SHALL assert every stall and set halted_op=1 until reset, ignoring all inputs.
REQ-022 Opcodes LUI, AUIPC and JAL SHALL never raise load-use.

Reset
REQ-023 On reset the state SHALL be RUN, the wait counter 0, halted_op 0, and both perf counters 0.
REQ-024 With reset=1 all control outputs SHALL be 0 in that cycle, including reset arriving mid-MEM_WAIT or in HALT.

Configuration
REQ-025 Macro HAZARD_CTRL_PERF_CNT_EN defined: stall_count_op SHALL count cycles with pc_stall_op=1, and flush_count_op SHALL count cycles with IF_ID_flush_op=1; both saturate at 32'hFFFF_FFFF.
REQ-026 Macro HAZARD_CTRL_PERF_CNT_EN undefined: both counters SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-027 CORE_PKG SHALL hold the hazard_state enum and the default MEM_TIMEOUT_CYCLES constant; opcode constants SHALL be reused from CORE_PKG.
REQ-028 The saturating counter SHALL be a sub-module hazard_perf_counter, instantiated twice under the macro.

Verification
REQ-029 The bench SHALL cover load-use: ID_EX_mem_read=1, dest=5, OP with rs2=5 -> one cycle of pc/IF_ID stall and ID_EX bubble, then state 0.
REQ-030 The bench SHALL cover a memory stall: dmem_req=1 and ack=0 for 3 cycles, then ack=1 -> 3 cycles of stalls in state 1, release on the ack cycle, then state 0.
REQ-031 The bench SHALL cover a simultaneous event: branch_taken=1 and load-use on the same cycle -> flushes only, no bubble, then state 2 for one cycle.
REQ-032 The bench SHALL cover timeout: MEM_TIMEOUT_CYCLES=4 and ack never arrives -> HALT (state 3) and halted_op=1 after 4 wait cycles; reset then returns the state to 0 with all outputs 0.
REQ-033 The bench SHALL cover x0 and the counters: dest=0 load with rs1=0 -> no stall; with the macro on, 10 stall cycles -> stall_count_op=10.
